timer_sequencer: RTL and testbench

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

---
 rtl/timer_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_timer_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : timer_sequencer                                                 |
// | Purpose  : MM:SS BCD countdown timer with load/start/stop/clear control    |
// |            and a tick-timed alarm window after expiry.                     |
// |            Optional door interlock: define TIMER_DOOR_INTERLOCK_EN.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module timer_sequencer #(
  parameter int ALARM_TICKS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        load,
  input  logic [15:0] load_bcd,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
`ifdef TIMER_DOOR_INTERLOCK_EN
  input  logic        door_open,
`endif
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        done,
  output logic        alarm,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_t;

  localparam logic [3:0] c_alarm_last = 4'(ALARM_TICKS - 1);

  state_t      state_q, state_d;
  logic [15:0] time_q, time_d;
  logic [3:0]  alarm_cnt_q, alarm_cnt_d;
  logic        done_q, done_d;
  logic        running_q;
  logic        alarm_q;

  logic        w_door;
  logic        w_sel_load;
  logic        w_sel_stop;
  logic        w_sel_start;
  logic [15:0] w_load_clamped;
  logic [15:0] w_time_dec;

`ifdef TIMER_DOOR_INTERLOCK_EN
  assign w_door = door_open;
`else
  assign w_door = 1'b0;
`endif

  // Only the highest-priority asserted command is evaluated; clear is handled first.
  assign w_sel_load  = ~clear & load;
  assign w_sel_stop  = ~clear & ~load & stop;
  assign w_sel_start = ~clear & ~load & ~stop & start & ~w_door;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Each seconds digit borrows independently, so 60..99 seconds count down naturally.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      su = 4'd9;
    end else begin
      if (mu != 4'd0) begin
        mu = mu - 4'd1;
      end else begin
        mt = mt - 4'd1;
        mu = 4'd9;
      end
      st = 4'd5;
      su = 4'd9;
    end
    return {mt, mu, st, su};
  endfunction

  assign w_load_clamped = {clamp_digit(load_bcd[15:12]), clamp_digit(load_bcd[11:8]),
                           clamp_digit(load_bcd[7:4]),   clamp_digit(load_bcd[3:0])};
  assign w_time_dec     = bcd_dec(time_q);

  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    alarm_cnt_d = alarm_cnt_q;
    done_d      = 1'b0;

    if (clear) begin
      state_d     = ST_IDLE;
      time_d      = 16'h0000;
      alarm_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_sel_load) begin
            time_d  = w_load_clamped;
            state_d = (w_load_clamped != 16'h0000) ? ST_READY : ST_IDLE;
          end
        end

        ST_READY, ST_PAUSE: begin
          if (w_sel_load) begin
            time_d  = w_load_clamped;
            state_d = (w_load_clamped != 16'h0000) ? ST_READY : ST_IDLE;
          end else if (w_sel_start) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          if (w_door || w_sel_stop) begin
            state_d = ST_PAUSE;
          end else if (tick_1hz) begin
            // A zero time here cannot arise normally; treat it as expiry rather than wrap.
            if (time_q == 16'h0001 || time_q == 16'h0000) begin
              time_d      = 16'h0000;
              state_d     = ST_ALARM;
              alarm_cnt_d = 4'd0;
              done_d      = 1'b1;
            end else begin
              time_d = w_time_dec;
            end
          end
        end

        ST_ALARM: begin
          if (w_sel_start) begin
            state_d     = ST_IDLE;
            alarm_cnt_d = 4'd0;
          end else if (tick_1hz) begin
            if (alarm_cnt_q >= c_alarm_last) begin
              state_d     = ST_IDLE;
              alarm_cnt_d = 4'd0;
            end else begin
              alarm_cnt_d = alarm_cnt_q + 4'd1;
            end
          end
        end

        default: begin
          state_d     = ST_IDLE;
          alarm_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      time_q      <= 16'h0000;
      alarm_cnt_q <= 4'd0;
      done_q      <= 1'b0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      alarm_cnt_q <= alarm_cnt_d;
      done_q      <= done_d;
      running_q   <= (state_d == ST_RUN);
      alarm_q     <= (state_d == ST_ALARM);
    end
  end

  assign time_bcd = time_q;
  assign running  = running_q;
  assign done     = done_q;
  assign alarm    = alarm_q;
  assign state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_timer_sequencer                                              |
// | Purpose  : Directed self-checking bench for timer_sequencer.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_timer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_bcd = 16'h0000;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
`ifdef TIMER_DOOR_INTERLOCK_EN
  logic        door_open = 1'b0;
`endif
  logic [15:0] time_bcd;
  logic        running;
  logic        done;
  logic        alarm;
  logic [2:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;

  timer_sequencer #(.ALARM_TICKS(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .load     (load),
    .load_bcd (load_bcd),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
`ifdef TIMER_DOOR_INTERLOCK_EN
    .door_open(door_open),
`endif
    .time_bcd (time_bcd),
    .running  (running),
    .done     (done),
    .alarm    (alarm),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle cycle, then a one-cycle tick; outputs are sampled just after the tick edge.
  task automatic tick();
    step();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_bcd = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    check("rst_state", state_o, 0);
    check("rst_time", time_bcd, 16'h0000);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_alarm", alarm, 0);
    rst = 1'b1;

    // 01:03 countdown across a minute borrow
    do_load(16'h0103);
    check("load_ready", state_o, 1);
    check("load_time", time_bcd, 16'h0103);
    do_start();
    check("start_run", state_o, 2);
    check("start_running", running, 1);
    tick(); check("t1", time_bcd, 16'h0102);
    tick(); check("t2", time_bcd, 16'h0101);
    tick(); check("t3", time_bcd, 16'h0100);
    tick(); check("t4_borrow", time_bcd, 16'h0059);

    // stop and tick together: pause wins, time frozen
    do_clear();
    check("clear_state", state_o, 0);
    check("clear_time", time_bcd, 16'h0000);
    do_load(16'h0230);
    do_start();
    stop = 1'b1; tick_1hz = 1'b1;
    step();
    stop = 1'b0; tick_1hz = 1'b0;
    check("stop_pause", state_o, 3);
    check("stop_frozen", time_bcd, 16'h0230);
    check("stop_running", running, 0);
    tick(); check("pause_tick_ignored", time_bcd, 16'h0230);
    do_start();
    check("resume_run", state_o, 2);
    tick(); check("resume_tick", time_bcd, 16'h0229);

    // load is ignored while running
    do_load(16'h0300);
    check("load_in_run", time_bcd, 16'h0229);
    check("load_in_run_state", state_o, 2);

    // 00:75 through expiry and the alarm window
    do_clear();
    do_load(16'h0075);
    do_start();
    tick(); check("s75_first", time_bcd, 16'h0074);
    for (int i = 0; i < 73; i++) tick();
    check("s75_at_one", time_bcd, 16'h0001);
    tick();
    check("expire_time", time_bcd, 16'h0000);
    check("expire_state", state_o, 4);
    check("expire_done", done, 1);
    check("expire_alarm", alarm, 1);
    check("expire_running", running, 0);
    step();
    check("done_one_cycle", done, 0);
    check("alarm_held", alarm, 1);
    tick(); tick();
    check("alarm_after_2", state_o, 4);
    tick();
    check("alarm_end_state", state_o, 0);
    check("alarm_end_alarm", alarm, 0);

    // start exits ALARM immediately
    do_load(16'h0001);
    do_start();
    tick();
    check("short_alarm", state_o, 4);
    do_start();
    check("alarm_start_exit", state_o, 0);

    // zero load with start stays idle; clamping of illegal digits
    load = 1'b1; start = 1'b1; load_bcd = 16'h0000;
    step();
    load = 1'b0; start = 1'b0;
    check("zero_load_idle", state_o, 0);
    do_start();
    check("start_in_idle", state_o, 0);
    do_load(16'hAB9F);
    check("clamp_time", time_bcd, 16'h9999);
    check("clamp_ready", state_o, 1);

    // reset mid-run with a tick present
    do_clear();
    do_load(16'h0512);
    do_start();
    rst = 1'b0; tick_1hz = 1'b1;
    step();
    rst = 1'b1; tick_1hz = 1'b0;
    check("midrun_rst_state", state_o, 0);
    check("midrun_rst_time", time_bcd, 16'h0000);
    check("midrun_rst_outs", {running, done, alarm}, 3'b000);

`ifdef TIMER_DOOR_INTERLOCK_EN
    do_load(16'h0010);
    do_start();
    door_open = 1'b1;
    step();
    check("door_pause", state_o, 3);
    do_start();
    check("door_start_blocked", state_o, 3);
    door_open = 1'b0;
    do_start();
    check("door_closed_run", state_o, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
